// File: rtl/tiny_dnn_seq.sv
// tiny_dnn_seq: sequencer for a single tiny_dnn_core MAC engine.
//
// Loads a weight set (len weights + bias) into the core, or runs one dot
// product (len inputs + bias) and returns the neuron value as a held result.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   cmd_load, cmd_run   IDLE-only commands; len sampled on accept
//   busy                high outside IDLE (and while the bias write is on the bus)
//   w_valid/w_ready     weight/bias stream, w_data
//   in_valid/in_ready   input activation stream, in_d
//   res_valid/res_ready result handshake, res held until accepted
//   core_*              registered core controls; core_sum is the accumulator
module tiny_dnn_seq #(
  parameter int F_SIZE = 512,
  parameter int AW     = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_load,
  input  logic          cmd_run,
  input  logic [AW-1:0] len,
  output logic          busy,
  input  logic          w_valid,
  output logic          w_ready,
  input  real           w_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  real           in_d,
  output logic          res_valid,
  input  logic          res_ready,
  output real           res,
  output logic          core_init,
  output logic          core_write,
  output logic          core_bwrite,
  output logic          core_exec,
  output logic          core_bias,
  output logic [AW-1:0] core_a,
  output real           core_d,
  output real           core_wd,
  input  real           core_sum
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_LOAD_W  = 4'd1;
  localparam logic [3:0] S_LOAD_B  = 4'd2;
  localparam logic [3:0] S_CLEAR   = 4'd3;
  localparam logic [3:0] S_RUN     = 4'd4;
  localparam logic [3:0] S_BIAS    = 4'd5;
  localparam logic [3:0] S_DRAIN   = 4'd6;
  localparam logic [3:0] S_CAPTURE = 4'd7;
  localparam logic [3:0] S_OUT     = 4'd8;

  localparam int unsigned   LMAX = F_SIZE - 1;
  localparam logic [AW-1:0] ONE  = AW'(1);

  logic [3:0]    state;
  logic [AW-1:0] cnt, len_q, len_c;
  real           d_hold;   // input word waiting one cycle to line up with the core's weight read
  logic          w_acc, in_acc;

  // Address F_SIZE-1 holds the bias, so at most F_SIZE-1 elements per neuron.
  assign len_c = (32'(len) > LMAX) ? AW'(LMAX) : len;

  assign w_ready  = (state == S_LOAD_W) || (state == S_LOAD_B);
  assign in_ready = (state == S_RUN);
  // Stretch busy over the cycle the bias write is presented to the core.
  assign busy     = (state != S_IDLE) || core_bwrite;
  assign w_acc    = w_valid && w_ready;
  assign in_acc   = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      len_q       <= '0;
      d_hold      <= 0.0;
      core_init   <= 1'b0;
      core_write  <= 1'b0;
      core_bwrite <= 1'b0;
      core_exec   <= 1'b0;
      core_bias   <= 1'b0;
      core_a      <= '0;
      core_d      <= 0.0;
      core_wd     <= 0.0;
      res         <= 0.0;
      res_valid   <= 1'b0;
    end else begin
      core_init   <= 1'b0;
      core_write  <= 1'b0;
      core_bwrite <= 1'b0;
      core_exec   <= 1'b0;
      core_bias   <= 1'b0;
      core_a      <= '0;
      // The core latches mem[core_a] on exec; the matching data follows a cycle later.
      if (core_exec) core_d <= d_hold;

      case (state)
        S_IDLE: begin
          if (cmd_load) begin
            len_q <= len_c;
            cnt   <= '0;
            state <= (len_c == '0) ? S_LOAD_B : S_LOAD_W;
          end else if (cmd_run) begin
            len_q <= len_c;
            cnt   <= '0;
            state <= S_CLEAR;
          end
        end
        S_LOAD_W: begin
          if (w_acc) begin
            core_write <= 1'b1;
            core_a     <= cnt;
            core_wd    <= w_data;
            cnt        <= cnt + ONE;
            if (cnt + ONE == len_q) state <= S_LOAD_B;
          end
        end
        S_LOAD_B: begin
          if (w_acc) begin
            core_write  <= 1'b1;
            core_bwrite <= 1'b1;
            core_wd     <= w_data;
            state       <= S_IDLE;
          end
        end
        S_CLEAR: begin
          // Previous run fully drained before OUT, so nothing is in flight in the core.
          core_init <= 1'b1;
          state     <= (len_q == '0) ? S_BIAS : S_RUN;
        end
        S_RUN: begin
          if (in_acc) begin
            core_exec <= 1'b1;
            core_a    <= cnt;
            d_hold    <= in_d;
            cnt       <= cnt + ONE;
            if (cnt + ONE == len_q) state <= S_BIAS;
          end
        end
        S_BIAS: begin
          // Registered, so the bias pulse lands the cycle after the last exec.
          core_bias <= 1'b1;
          cnt       <= '0;
          state     <= S_DRAIN;
        end
        S_DRAIN: begin
          cnt <= cnt + ONE;
          if (cnt == ONE) state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          res       <= core_sum;
          res_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tiny_dnn_seq.sv
// Bench for tiny_dnn_seq with a behavioral tiny_dnn_core attached.
// Expected results are computed from the driven weights/inputs and queued;
// a negedge monitor pops and compares them as the DUT produces them.
module tb_tiny_dnn_seq;
  localparam int F_SIZE = 512;
  localparam int AW     = 9;

  logic clk, reset, cmd_load, cmd_run, busy;
  logic [AW-1:0] len;
  logic w_valid, w_ready, in_valid, in_ready, res_valid, res_ready;
  real  w_data, in_d, res, core_d, core_wd, core_sum;
  logic core_init, core_write, core_bwrite, core_exec, core_bias;
  logic [AW-1:0] core_a;

  tiny_dnn_seq #(.F_SIZE(F_SIZE), .AW(AW)) dut (
    .clk(clk), .reset(reset), .cmd_load(cmd_load), .cmd_run(cmd_run), .len(len),
    .busy(busy), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_d(in_d),
    .res_valid(res_valid), .res_ready(res_ready), .res(res),
    .core_init(core_init), .core_write(core_write), .core_bwrite(core_bwrite),
    .core_exec(core_exec), .core_bias(core_bias), .core_a(core_a),
    .core_d(core_d), .core_wd(core_wd), .core_sum(core_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---- behavioral core: registered weight read, data one cycle behind exec
  real mem [F_SIZE];
  real w_r, b_r;
  logic ex_d, b_d;
  initial begin
    for (int i = 0; i < F_SIZE; i++) mem[i] = 0.0;
    core_sum = 0.0; w_r = 0.0; b_r = 0.0; ex_d = 1'b0; b_d = 1'b0;
  end
  always @(posedge clk) begin
    if (core_write) mem[core_bwrite ? F_SIZE-1 : int'(core_a)] <= core_wd;
    ex_d <= core_exec;
    b_d  <= core_bias;
    w_r  <= mem[core_a];
    b_r  <= mem[F_SIZE-1];
    if (core_init) core_sum <= 0.0;
    else core_sum <= core_sum + (ex_d ? w_r * core_d : 0.0) + (b_d ? b_r : 0.0);
  end

  // ---- checking
  int n_tests = 0, n_fail = 0;
  task automatic chk(input string tag, input real got, input real exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %g expected %g", tag, got, exp);
    end
  endtask

  // ---- scoreboard queues and stats
  real er_q[$];                       // results
  int  ea_q[$];  real ed_q[$];        // exec address / data
  int  ewa_q[$]; real eww_q[$]; int ewb_q[$];  // writes
  int  exec_cnt, burst_cnt, init_cnt, bias_cnt, inr_cnt, ovl, rise_cnt, wr_cnt;
  bit  prev_exec, prev_rv, pend_d;
  real pend_dv;

  task automatic clr_stats();
    exec_cnt = 0; burst_cnt = 0; init_cnt = 0; bias_cnt = 0;
    inr_cnt = 0; ovl = 0; rise_cnt = 0; wr_cnt = 0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (core_exec && core_bias) ovl++;
      if (core_write && (core_exec || core_bias)) ovl++;
      if (core_init && (core_exec || core_bias)) ovl++;
      if (pend_d) begin chk("core_d_skew", core_d, pend_dv); pend_d = 1'b0; end
      if (core_exec) begin
        exec_cnt++;
        if (!prev_exec) burst_cnt++;
        if (ea_q.size() == 0) chk("exec_unexpected", 1, 0);
        else begin
          chk("exec_a", core_a, ea_q.pop_front());
          pend_dv = ed_q.pop_front(); pend_d = 1'b1;
        end
      end
      prev_exec = core_exec;
      if (core_init) init_cnt++;
      if (core_bias) bias_cnt++;
      if (in_ready)  inr_cnt++;
      if (core_write) begin
        wr_cnt++;
        if (ewa_q.size() == 0) chk("write_unexpected", 1, 0);
        else begin
          chk("write_a",  core_a,      ewa_q.pop_front());
          chk("write_wd", core_wd,     eww_q.pop_front());
          chk("write_bw", core_bwrite, ewb_q.pop_front());
        end
      end
      if (res_valid && !prev_rv) rise_cnt++;
      prev_rv = res_valid;
      if (res_valid && res_ready) begin
        if (er_q.size() == 0) chk("res_unexpected", 1, 0);
        else chk("res", res, er_q.pop_front());
      end
    end
  end

  // ---- stimulus helpers (called at a negedge, return at a negedge)
  real wts[4];
  real bias_v;
  real wq[$], dq[$];

  task automatic send_w(input real x);
    int t = 0;
    w_valid = 1'b1; w_data = x;
    while (!w_ready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) chk("w_timeout", 0, 1);
    @(negedge clk); w_valid = 1'b0;
  endtask

  task automatic send_d(input real x);
    int t = 0;
    in_valid = 1'b1; in_d = x;
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) chk("in_timeout", 0, 1);
    @(negedge clk); in_valid = 1'b0;
  endtask

  task automatic wait_res();
    int t = 0;
    do begin @(negedge clk); t++; end while (!(res_valid && res_ready) && t < 300);
    if (t >= 300) chk("res_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic do_load(input int n, input real b);
    for (int i = 0; i < n; i++) begin
      ewa_q.push_back(i); eww_q.push_back(wq[i]); ewb_q.push_back(0); wts[i] = wq[i];
    end
    ewa_q.push_back(0); eww_q.push_back(b); ewb_q.push_back(1); bias_v = b;
    cmd_load = 1'b1; len = AW'(n); @(negedge clk); cmd_load = 1'b0;
    for (int i = 0; i < n; i++) send_w(wq[i]);
    send_w(b);
    chk("busy_on_bwrite", busy, 1);
    @(negedge clk);
    chk("busy_drop", busy, 0);
  endtask

  task automatic do_run(input int n, input int gap, input int nsend, input bit wres);
    real e = bias_v;
    for (int i = 0; i < n; i++) begin
      e += wts[i] * dq[i]; ea_q.push_back(i); ed_q.push_back(dq[i]);
    end
    er_q.push_back(e);
    cmd_run = 1'b1; len = AW'(n); @(negedge clk); cmd_run = 1'b0;
    for (int i = 0; i < nsend; i++) begin
      send_d(dq[i]);
      if (i < nsend - 1) repeat (gap) @(negedge clk);
    end
    if (wres && nsend == n) wait_res();
  endtask

  initial begin
    int t;
    reset = 1'b1; cmd_load = 0; cmd_run = 0; len = '0;
    w_valid = 0; w_data = 0.0; in_valid = 0; in_d = 0.0; res_ready = 1'b1;
    prev_exec = 0; prev_rv = 0; pend_d = 0; pend_dv = 0.0; bias_v = 0.0;
    for (int i = 0; i < 4; i++) wts[i] = 0.0;
    clr_stats();
    #3;
    chk("rst_busy", busy, 0);       chk("rst_w_ready", w_ready, 0);
    chk("rst_in_ready", in_ready, 0); chk("rst_res_valid", res_valid, 0);
    chk("rst_core_ctl", {core_init, core_write, core_bwrite, core_exec, core_bias}, 0);
    chk("rst_core_a", core_a, 0);   chk("rst_res", res, 0.0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // load 1,2,3 + bias 0.5
    clr_stats();
    wq = {1.0, 2.0, 3.0};
    do_load(3, 0.5);
    chk("load_writes", wr_cnt, 4);

    // plain run
    clr_stats();
    dq = {1.0, 1.0, 2.0};
    do_run(3, 0, 3, 1);
    chk("run_exec_cnt", exec_cnt, 3);  chk("run_bursts", burst_cnt, 1);
    chk("run_res_once", rise_cnt, 1);  chk("run_init", init_cnt, 1);
    chk("run_ovl", ovl, 0);

    // bubbly input
    clr_stats();
    do_run(3, 2, 3, 1);
    chk("bub_exec_cnt", exec_cnt, 3);  chk("bub_bursts", burst_cnt, 3);
    chk("bub_ovl", ovl, 0);            chk("bub_res_once", rise_cnt, 1);

    // len=0 run: bias only
    clr_stats();
    dq.delete();
    do_run(0, 0, 0, 1);
    chk("len0_exec", exec_cnt, 0);     chk("len0_init", init_cnt, 1);
    chk("len0_bias", bias_cnt, 1);

    // back-pressure, then two back-to-back runs
    clr_stats();
    res_ready = 1'b0;
    dq = {1.0, 1.0, 2.0};
    do_run(3, 0, 3, 0);
    t = 0;
    while (!res_valid && t < 300) begin @(negedge clk); t++; end
    if (t >= 300) chk("bp_timeout", 0, 1);
    repeat (5) @(negedge clk);
    chk("bp_hold_res", res, 9.5);      chk("bp_hold_vld", res_valid, 1);
    @(posedge clk); #2 res_ready = 1'b1;
    wait_res();
    dq = {2.0, 0.0, 0.0};
    do_run(3, 0, 3, 1);
    do_run(3, 0, 3, 1);
    chk("b2b_inits", init_cnt, 3);     chk("b2b_res_cnt", rise_cnt, 3);
    chk("b2b_ovl", ovl, 0);

    // reset mid-run after one of three beats
    dq = {1.0, 1.0, 2.0};
    do_run(3, 0, 1, 0);
    @(negedge clk);
    chk("pre_rst_in_ready", in_ready, 1);
    chk("pre_rst_core_d", core_d, 1.0);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);      chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_core_d", core_d, 0.0); chk("mid_rst_exec", core_exec, 0);
    @(negedge clk);
    er_q.delete(); ea_q.delete(); ed_q.delete(); pend_d = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    clr_stats();
    do_run(3, 0, 3, 1);
    chk("rerun_res_once", rise_cnt, 1);

    // command collision: load wins, a run pulse during LOAD_W is dropped
    clr_stats();
    wq = {1.0, 2.0, 3.0};
    for (int i = 0; i < 3; i++) begin ewa_q.push_back(i); eww_q.push_back(wq[i]); ewb_q.push_back(0); end
    ewa_q.push_back(0); eww_q.push_back(0.5); ewb_q.push_back(1);
    cmd_load = 1'b1; cmd_run = 1'b1; len = AW'(3);
    @(negedge clk); cmd_load = 1'b0; cmd_run = 1'b0;
    chk("coll_w_ready", w_ready, 1);   chk("coll_in_ready", in_ready, 0);
    send_w(1.0);
    cmd_run = 1'b1;
    send_w(2.0);
    cmd_run = 1'b0;
    send_w(3.0);
    send_w(0.5);
    repeat (3) @(negedge clk);
    chk("coll_no_init", init_cnt, 0);  chk("coll_no_in_ready", inr_cnt, 0);
    chk("coll_idle", busy, 0);         chk("coll_writes", wr_cnt, 4);
    clr_stats();
    do_run(3, 0, 3, 1);

    chk("sb_empty", er_q.size() + ea_q.size() + ewa_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
